// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types, constants and divider helper for the I2C write engine.
package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STA,
    BIT,
    STO
  } state_e;

  typedef logic [1:0] quarter_t;

  localparam int unsigned BYTES          = 3;
  localparam int unsigned SLOTS_PER_BYTE = 9;

  // Clock cycles per quarter SCL period, truncated.
  function automatic int unsigned calc_div(input int unsigned clk, input int unsigned i2c);
    return clk / (4 * i2c);
  endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// rtl/i2c_tick_gen.sv - quarter-period tick divider with clear and stall.
module i2c_tick_gen #(
  parameter int unsigned DIV = 31
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic stall,
  output logic tick
);

  localparam int unsigned W = $clog2(DIV);

  logic [W-1:0] cnt_q, cnt_d;
  logic         at_top;

  assign at_top = (cnt_q == W'(DIV - 1));
  assign tick   = at_top && !stall;

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clear || stall || at_top) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/i2c_write_engine.sv
// rtl/i2c_write_engine.sv - single-master 3-byte I2C write with STOP, open-drain SCL/SDA.
// Define I2C_CLK_STRETCH_EN to let a slave stretch SCL after each master release.
module i2c_write_engine
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_Freq = 50_000_000,
  parameter int unsigned I2C_Freq = 400_000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [23:0] I2C_DATA,
  input  logic        START,
  output logic        END,
  output logic        ACK,
  inout  wire         I2C_SCL,
  inout  wire         I2C_SDA
);

  localparam int unsigned DIV       = calc_div(CLK_Freq, I2C_Freq);
  localparam logic [3:0]  LAST_BIT  = 4'(SLOTS_PER_BYTE - 1);
  localparam logic [1:0]  LAST_BYTE = 2'(BYTES - 1);

  if (DIV < 2) begin : g_bad_div
    $error("i2c_write_engine: CLK_Freq/(4*I2C_Freq) must be at least 2");
  end

  state_e      state_q, state_d;
  quarter_t    quarter_q, quarter_d;
  logic [3:0]  bit_idx_q, bit_idx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [23:0] shift_q, shift_d;
  logic        scl_oe_q, scl_oe_d;
  logic        sda_oe_q, sda_oe_d;
  logic        end_q, end_d;
  logic        ack_q, ack_d;
  logic        armed_q, armed_d;
  logic        accept;
  logic        tick;
  logic        stall;

  i2c_tick_gen #(
    .DIV(DIV)
  ) u_tick_gen (
    .clk  (CLK),
    .rst  (RESET),
    .clear(accept),
    .stall(stall),
    .tick (tick)
  );

`ifdef I2C_CLK_STRETCH_EN
  logic scl_wait_q, scl_wait_d;

  // Armed by each tick that releases SCL; cleared once the line is seen high.
  always_comb begin
    scl_wait_d = scl_wait_q;
    if (scl_wait_q && I2C_SCL) begin
      scl_wait_d = 1'b0;
    end
    if (tick && quarter_q == 2'd1 && (state_q == BIT || state_q == STO)) begin
      scl_wait_d = 1'b1;
    end
  end

  assign stall = scl_wait_q && !I2C_SCL;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      scl_wait_q <= 1'b0;
    end else begin
      scl_wait_q <= scl_wait_d;
    end
  end
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    quarter_d  = quarter_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    scl_oe_d   = scl_oe_q;
    sda_oe_d   = sda_oe_q;
    end_d      = end_q;
    ack_d      = ack_q;
    armed_d    = armed_q;
    accept     = 1'b0;

    if (end_q && !START) begin
      armed_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (armed_q && START) begin
          accept    = 1'b1;
          shift_d   = I2C_DATA;
          ack_d     = 1'b0;
          end_d     = 1'b0;
          armed_d   = 1'b0;
          quarter_d = '0;
          state_d   = STA;
        end
      end
      STA: begin
        if (tick) begin
          if (quarter_q == 2'd0) begin
            sda_oe_d  = 1'b1;
            quarter_d = 2'd1;
          end else begin
            scl_oe_d   = 1'b1;
            quarter_d  = '0;
            bit_idx_d  = '0;
            byte_idx_d = '0;
            state_d    = BIT;
          end
        end
      end
      BIT: begin
        if (tick) begin
          quarter_d = quarter_q + 2'd1;
          case (quarter_q)
            2'd0: sda_oe_d = (bit_idx_q == LAST_BIT) ? 1'b0 : !shift_q[23];
            2'd1: scl_oe_d = 1'b0;
            2'd2: begin
              if (bit_idx_q == LAST_BIT && I2C_SDA) begin
                ack_d = 1'b1;
              end
            end
            default: begin
              scl_oe_d = 1'b1;
              if (bit_idx_q == LAST_BIT) begin
                bit_idx_d = '0;
                // ack_q set here means this slot was NACKed: abandon remaining bytes.
                if (ack_q || byte_idx_q == LAST_BYTE) begin
                  state_d = STO;
                end else begin
                  byte_idx_d = byte_idx_q + 2'd1;
                end
              end else begin
                bit_idx_d = bit_idx_q + 4'd1;
                shift_d   = {shift_q[22:0], 1'b0};
              end
            end
          endcase
        end
      end
      STO: begin
        if (tick) begin
          quarter_d = quarter_q + 2'd1;
          case (quarter_q)
            2'd0: sda_oe_d = 1'b1;
            2'd1: scl_oe_d = 1'b0;
            2'd2: sda_oe_d = 1'b0;
            default: begin
              end_d   = 1'b1;
              state_d = IDLE;
            end
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      quarter_q  <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      scl_oe_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
      end_q      <= 1'b1;
      ack_q      <= 1'b0;
      armed_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      quarter_q  <= quarter_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      scl_oe_q   <= scl_oe_d;
      sda_oe_q   <= sda_oe_d;
      end_q      <= end_d;
      ack_q      <= ack_d;
      armed_q    <= armed_d;
    end
  end

  assign END     = end_q;
  assign ACK     = ack_q;
  assign I2C_SCL = scl_oe_q ? 1'b0 : 1'bz;
  assign I2C_SDA = sda_oe_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_write_engine.sv
// tb/tb_i2c_write_engine.sv - randomized bench with I2C slave model and transaction reference model.
module tb_i2c_write_engine;

  localparam int CLK_HZ = 50_000_000;
  localparam int I2C_HZ = 400_000;
  localparam int DIV    = CLK_HZ / (4 * I2C_HZ);

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        START = 1'b0;
  logic [23:0] I2C_DATA = '0;
  wire         END_o;
  wire         ACK_o;
  wire         scl_bus;
  wire         sda_bus;

  logic slave_sda_low = 1'b0;
  logic slave_scl_low = 1'b0;

  pullup (scl_bus);
  pullup (sda_bus);
  assign scl_bus = slave_scl_low ? 1'b0 : 1'bz;
  assign sda_bus = slave_sda_low ? 1'b0 : 1'bz;

  i2c_write_engine #(
    .CLK_Freq(CLK_HZ),
    .I2C_Freq(I2C_HZ)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .I2C_DATA(I2C_DATA),
    .START   (START),
    .END     (END_o),
    .ACK     (ACK_o),
    .I2C_SCL (scl_bus),
    .I2C_SDA (sda_bus)
  );

  always #10 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  int         start_cnt = 0;
  int         stop_cnt = 0;
  int         rise_cnt = 0;
  logic [7:0] rx_q[$];
  int         nack_sel = 3;
  bit         stretch_arm = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Bus monitor and ACKing slave; all bus observation happens on the falling clock edge.
  initial begin
    logic s, d, prev_s, prev_d;
    int   pos, stretch_left;
    logic [7:0] cur;
    prev_s = 1'b1;
    prev_d = 1'b1;
    pos = 0;
    cur = '0;
    stretch_left = 0;
    forever begin
      @(negedge CLK);
      s = (scl_bus !== 1'b0);
      d = (sda_bus !== 1'b0);
      if (stretch_left > 0) begin
        stretch_left--;
        if (stretch_left == 0) slave_scl_low = 1'b0;
      end
      if (s && prev_s && prev_d && !d) begin
        start_cnt++;
        pos = 0;
        cur = '0;
        rx_q.delete();
      end
      if (s && prev_s && !prev_d && d) stop_cnt++;
      if (s && !prev_s) begin
        rise_cnt++;
        if (pos < 8) begin
          cur = {cur[6:0], d};
          pos++;
        end else begin
          rx_q.push_back(cur);
          pos = 0;
        end
      end
      if (!s && prev_s) begin
        if (pos == 8) begin
          slave_sda_low = (rx_q.size() != nack_sel);
          if (stretch_arm && rx_q.size() == 0) begin
            slave_scl_low = 1'b1;
            stretch_left = 100 + 2 * DIV + 4;
          end
        end else begin
          slave_sda_low = 1'b0;
        end
      end
      prev_s = s;
      prev_d = d;
    end
  end

  task automatic run_txn(input logic [23:0] data, input int nack_at, input bit hold_start,
                         input bit stretch);
    int n, nb, exp_cyc, s0, p0, r0;
    logic [7:0] eb;
    nb = (nack_at < 3) ? nack_at + 1 : 3;
    exp_cyc = (2 + 4 * 9 * nb + 4) * DIV;
    nack_sel = nack_at;
    stretch_arm = stretch;
    s0 = start_cnt;
    p0 = stop_cnt;
    r0 = rise_cnt;
    @(negedge CLK);
    I2C_DATA = data;
    START = 1'b1;
    @(negedge CLK);
    check("end_fall", 32'(END_o), 32'd0);
    I2C_DATA = 24'($urandom);
    if (!hold_start) START = 1'b0;
    n = 0;
    while (END_o !== 1'b1 && n < 20000) begin
      @(negedge CLK);
      n++;
    end
    if (stretch) check("dur_stretch", 32'(n >= exp_cyc + 100), 32'd1);
    else check("duration", 32'(n), 32'(exp_cyc));
    check("ack", 32'(ACK_o), 32'(nack_at < 3));
    repeat (40) @(negedge CLK);
    check("end_idle", 32'(END_o), 32'd1);
    check("starts", 32'(start_cnt - s0), 32'd1);
    check("stops", 32'(stop_cnt - p0), 32'd1);
    check("scl_rises", 32'(rise_cnt - r0), 32'(9 * nb + 1));
    check("nbytes", 32'(rx_q.size()), 32'(nb));
    for (int k = 0; k < nb && k < rx_q.size(); k++) begin
      eb = 8'(data >> (16 - 8 * k));
      check($sformatf("byte%0d", k), 32'(rx_q[k]), 32'(eb));
    end
  endtask

  initial begin
    int n, r0, s0, nack;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    check("rst_end", 32'(END_o), 32'd1);
    check("rst_ack", 32'(ACK_o), 32'd0);
    check("rst_scl", 32'(scl_bus), 32'd1);
    check("rst_sda", 32'(sda_bus), 32'd1);

    run_txn(24'h72_41_10, 3, 1'b0, 1'b0);

    run_txn(24'h72_41_10, 0, 1'b0, 1'b0);
    r0 = rise_cnt;
    repeat (200) @(negedge CLK);
    check("nack_quiet", 32'(rise_cnt - r0), 32'd0);

    for (int i = 0; i < 3; i++) begin
      run_txn({7'($urandom), 1'b0, 16'($urandom)}, 3, 1'b0, 1'b0);
    end

    run_txn(24'($urandom), 3, 1'b1, 1'b0);
    s0 = start_cnt;
    repeat (200) @(negedge CLK);
    check("held_end", 32'(END_o), 32'd1);
    check("held_no_retrig", 32'(start_cnt - s0), 32'd0);
    START = 1'b0;
    run_txn(24'($urandom), 3, 1'b0, 1'b0);

    nack_sel = 3;
    r0 = rise_cnt;
    @(negedge CLK);
    I2C_DATA = 24'h72_41_10;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    n = 0;
    while (rise_cnt - r0 < 13 && n < 20000) begin
      @(negedge CLK);
      n++;
    end
    while (scl_bus !== 1'b0 && n < 20000) begin
      @(negedge CLK);
      n++;
    end
    repeat (DIV + 5) @(negedge CLK);
    check("pre_rst_scl", 32'(scl_bus), 32'd0);
    check("pre_rst_sda", 32'(sda_bus), 32'd0);
    RESET = 1'b1;
    @(negedge CLK);
    check("midrst_scl", 32'(scl_bus), 32'd1);
    check("midrst_sda", 32'(sda_bus), 32'd1);
    check("midrst_end", 32'(END_o), 32'd1);
    RESET = 1'b0;
    run_txn(24'h72_41_10, 3, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      nack = int'($urandom_range(0, 3));
      run_txn(24'($urandom), nack, 1'b0, 1'b0);
    end

`ifdef I2C_CLK_STRETCH_EN
    run_txn(24'h72_41_10, 3, 1'b0, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_write_engine.md
Name: i2c_write_engine

Overview:
- Single-master I2C write engine: sends one 3-byte transaction (slave address, sub-address, data), then a STOP.
- Sits directly downstream of the video-output register sequencer, which presents one 24-bit word per register write and walks its table on a START/END/ACK handshake.
- Drives an open-drain SCL/SDA pair to the HDMI transmitter at a parameterised bus rate.

Parameters:
- CLK_Freq, 50_000_000, CLK frequency in Hz.
- I2C_Freq, 400_000, SCL frequency in Hz.
- Derived constant DIV = CLK_Freq/(4*I2C_Freq), truncated (31 at defaults); DIV >= 2 is an elaboration-time check.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- I2C_DATA  in  24  [23:16] slave address incl. R/W=0, [15:8] sub-address, [7:0] data.
- START  in  1  level request; accepted only in IDLE while armed.
- END  out  1  1 = idle/done; 0 = transfer in progress.
- ACK  out  1  0 = all three bytes ACKed; 1 = a NACK occurred; valid while END=1.
- I2C_SCL  inout  1  open-drain clock: drives 0 or Z.
- I2C_SDA  inout  1  open-drain data: drives 0 or Z.

Behaviour:
- Reset values: END=1, ACK=0, SCL=Z, SDA=Z, state IDLE, armed=1, divider=0.
- Reset mid-transfer releases both lines on the next edge. No STOP is generated; the bus recovers on the next START condition.
- Tick: divider counts 0..DIV-1 and pulses tick at DIV-1. It is cleared on acceptance. All bus events occur on ticks (quarter SCL periods).
- Acceptance:
  - Condition: IDLE & armed & START.
  - Actions on that edge: latch I2C_DATA into shift register, clear ACK, END<=0, armed<=0.
  - armed returns to 1 only after START is sampled 0 while END=1.
  - A START held high across completion therefore never re-triggers.
- FSM states: IDLE, STA, BIT, STO.
  - STA, 2 ticks: tick1 SDA=0 (SCL Z); tick2 SCL=0.
  - BIT, 4 ticks per bit slot:
    - q0: SDA = bit (0→drive 0, 1→Z).
    - q1: SCL=Z.
    - q2: sample SDA (ACK slots only).
    - q3: SCL=0.
  - Slots: 8 data bits MSB-first, then 1 ACK slot with SDA released. Repeat for 3 bytes = 27 slots.
  - STO, 4 ticks: q0 SDA=0; q1 SCL=Z; q2 SDA=Z; q3 bus-free hold, then END<=1 and go to IDLE.
- ACK slot sampling: SDA=1 → ACK<=1 and jump to STO at the next tick, skipping the remaining slots.
- Full transaction = 2+108+4 = 114 ticks. At defaults END rises 114*31 = 3534 cycles after the acceptance edge.
- START changes while busy are ignored. I2C_DATA is don't-care after acceptance.
- Counters: bit index 0..8 (4 bits), byte index 0..2 (2 bits), quarter 0..3 (2 bits). No wrap beyond byte 2.

Optional Feature:
- Macro I2C_CLK_STRETCH_EN.
- Defined:
  - After every tick that releases SCL, sample I2C_SCL.
  - While it reads 0, hold the divider at 0 and freeze the FSM.
  - Resume with a full DIV count once SCL reads 1.
  - Timeout: none.
- Undefined: I2C_SCL is never sampled, and timing is exactly 114*DIV cycles.

Decomposition:
- Package i2c_pkg:
  - state enum (IDLE, STA, BIT, STO);
  - quarter type (2-bit);
  - function calc_div(clk, i2c);
  - localparams BYTES=3, SLOTS_PER_BYTE=9.
- Sub-module i2c_tick_gen (DIV counter with clear and stall inputs, tick output). The FSM stays in i2c_write_engine.

Test Plan:
- Reset, then START=1 with I2C_DATA=24'h72_41_10 and slave model ACKing all bytes:
  - END falls 1 cycle after accept and rises 3534 cycles later.
  - Decoded bytes are 72,41,10.
  - ACK=0; START then STOP observed.
- Slave NACKs the address byte: after the 9th slot, STOP follows immediately, END=1, ACK=1, and no further SCL pulses.
- Full handshake loop of the upstream sequencer (GO high, wait END low, GO low, wait END high) over 3 words: 3 transactions, ACK=0 each, no extra transfer.
- START held high through completion: exactly one transaction; a second starts only after START 0→1.
- RESET asserted at slot 13: SCL/SDA = Z and END=1 on the next cycle. The next START yields a clean 114-tick transfer.
- With I2C_CLK_STRETCH_EN, slave holds SCL low for 100 cycles at the first ACK slot: END rise is delayed by ≥100 cycles and the data is still correct.
